// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the sequential shift-add multiplier.
//   - state_e      : FSM state encoding (IDLE / RUN / DONE)
//   - clog2        : ceiling log2, used to size the iteration counter
//   - WIDTH_MIN/MAX: legal operand width range
//   - twos_negate  : two's-complement negate on a 64-bit container; callers
//                    zero-extend their operand and truncate the result.
package mult_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Returns at least 1 so a counter of this width is always declarable.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    function automatic logic [63:0] twos_negate(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

endpackage

// File: rtl/seq_array_multiplier.sv
// seq_array_multiplier: iterative shift-add multiplier, one partial product
// per clock, with valid/ready handshakes and optional signed mode.
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   in_valid    - operands a/b/signed_mode valid
//   in_ready    - high in IDLE, operands accepted on in_valid && in_ready
//   a, b        - WIDTH-bit multiplicand / multiplier
//   signed_mode - two's-complement operands when 1 (needs SIGNED_EN=1)
//   out_valid   - product valid (DONE state)
//   out_ready   - consumer accepts product
//   product     - 2*WIDTH-bit result, held until the next result or reset
//   busy        - high in RUN and DONE
module seq_array_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = clog2(WIDTH);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("seq_array_multiplier: WIDTH out of legal range");
        end
    endgenerate

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   shifted;
    logic [2*WIDTH-1:0]   final_product;

    // With SIGNED_EN=0 the signed path folds away entirely.
    assign signed_op = SIGNED_EN && signed_mode;

    // Magnitudes are kept unsigned in WIDTH bits, so |-2^(W-1)| = 2^(W-1) fits.
    assign a_mag = (signed_op && a[WIDTH-1]) ? WIDTH'(twos_negate(64'(a))) : a;
    assign b_mag = (signed_op && b[WIDTH-1]) ? WIDTH'(twos_negate(64'(b))) : b;

    // One extra bit keeps the carry, which shifts into acc's MSB.
    assign sum     = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    assign shifted = {sum, mplr_q[WIDTH-1:1]};
    assign final_product = neg_q ? (2*WIDTH)'(twos_negate(64'(shifted))) : shifted;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        neg_d     = neg_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = a_mag;
                    mplr_d  = b_mag;
                    neg_d   = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = shifted[2*WIDTH-1:WIDTH];
                mplr_d  = shifted[WIDTH-1:0];
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    product_d = final_product;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mplr_q    <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mplr_q    <= mplr_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
module tb_seq_array_multiplier;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    // Instance S: SIGNED_EN=1
    logic           in_valid_s, in_ready_s, sm_s, out_valid_s, out_ready_s, busy_s;
    logic [W-1:0]   a_s, b_s;
    logic [2*W-1:0] product_s;

    // Instance U: SIGNED_EN=0
    logic           in_valid_u, in_ready_u, sm_u, out_valid_u, out_ready_u, busy_u;
    logic [W-1:0]   a_u, b_u;
    logic [2*W-1:0] product_u;

    int tests;
    int failed;

    seq_array_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s), .in_ready(in_ready_s),
        .a(a_s), .b(b_s), .signed_mode(sm_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .product(product_s), .busy(busy_s)
    );

    seq_array_multiplier #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_u), .in_ready(in_ready_u),
        .a(a_u), .b(b_u), .signed_mode(sm_u),
        .out_valid(out_valid_u), .out_ready(out_ready_u),
        .product(product_u), .busy(busy_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit sel, input string tag,
                                 input logic iv, input logic ov, input logic bz);
        check({tag, "_in_ready"},  sel ? in_ready_u  : in_ready_s,  iv);
        check({tag, "_out_valid"}, sel ? out_valid_u : out_valid_s, ov);
        check({tag, "_busy"},      sel ? busy_u      : busy_s,      bz);
    endtask

    // Accept one operand pair and follow it to DONE, checking latency and product.
    task automatic start_op(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sm, input logic [2*W-1:0] exp, input string tag);
        @(negedge clk);
        if (sel) begin a_u = a; b_u = b; sm_u = sm; in_valid_u = 1'b1; end
        else     begin a_s = a; b_s = b; sm_s = sm; in_valid_s = 1'b1; end
        check({tag, "_idle_in_ready"}, sel ? in_ready_u : in_ready_s, 1'b1);
        @(posedge clk);
        #1;
        in_valid_s = 1'b0;
        in_valid_u = 1'b0;
        for (int i = 1; i <= W; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < W) check_outputs(sel, $sformatf("%s_run%0d", tag, i), 1'b0, 1'b0, 1'b1);
            else       check_outputs(sel, {tag, "_done"}, 1'b0, 1'b1, 1'b1);
        end
        check({tag, "_product"}, sel ? product_u : product_s, exp);
        $display("[TB] %s a=%h b=%h signed_mode=%0d product=%h expected=%h", tag, a, b, sm,
                 sel ? product_u : product_s, exp);
    endtask

    task automatic finish_op(input bit sel, input string tag);
        if (sel) out_ready_u = 1'b1; else out_ready_s = 1'b1;
        @(posedge clk);
        #1;
        out_ready_s = 1'b0;
        out_ready_u = 1'b0;
        @(negedge clk);
        check_outputs(sel, {tag, "_back_idle"}, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        rst_n = 1'b0;
        in_valid_s = 1'b0; a_s = '0; b_s = '0; sm_s = 1'b0; out_ready_s = 1'b0;
        in_valid_u = 1'b0; a_u = '0; b_u = '0; sm_u = 1'b0; out_ready_u = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs(1'b0, "reset_s", 1'b1, 1'b0, 1'b0);
        check("reset_s_product", product_s, 16'h0000);
        check_outputs(1'b1, "reset_u", 1'b1, 1'b0, 1'b0);
        check("reset_u_product", product_u, 16'h0000);
        rst_n = 1'b1;

        // out_ready while idle has no effect
        @(negedge clk);
        out_ready_s = 1'b1;
        @(negedge clk);
        out_ready_s = 1'b0;
        check_outputs(1'b0, "idle_out_ready", 1'b1, 1'b0, 1'b0);

        start_op(1'b0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, "unsigned_max");
        finish_op(1'b0, "unsigned_max");
        start_op(1'b0, 8'hFD, 8'h05, 1'b1, 16'hFFF1, "signed_mixed");
        finish_op(1'b0, "signed_mixed");
        start_op(1'b0, 8'h80, 8'h80, 1'b1, 16'h4000, "signed_extreme");
        finish_op(1'b0, "signed_extreme");
        start_op(1'b0, 8'h7F, 8'h81, 1'b1, 16'hC0FF, "signed_pos_neg");
        finish_op(1'b0, "signed_pos_neg");
        start_op(1'b0, 8'h00, 8'h55, 1'b0, 16'h0000, "zero_operand");
        finish_op(1'b0, "zero_operand");
        start_op(1'b1, 8'hFD, 8'h05, 1'b1, 16'h04F1, "signed_disabled");
        finish_op(1'b1, "signed_disabled");

        // Backpressure: hold out_ready low with a competing in_valid
        start_op(1'b0, 8'h0C, 8'h0B, 1'b0, 16'h0084, "backpressure");
        a_s = 8'h33; b_s = 8'h44; in_valid_s = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check_outputs(1'b0, $sformatf("bp_hold%0d", i), 1'b0, 1'b1, 1'b1);
            check($sformatf("bp_hold%0d_product", i), product_s, 16'h0084);
        end
        in_valid_s = 1'b0;
        finish_op(1'b0, "backpressure");
        check("bp_product_kept", product_s, 16'h0084);

        // Reset mid-RUN
        @(negedge clk);
        a_s = 8'h09; b_s = 8'h09; sm_s = 1'b0; in_valid_s = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs(1'b0, "midrun_reset", 1'b1, 1'b0, 1'b0);
        check("midrun_reset_product", product_s, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("post_reset%0d_out_valid", i), out_valid_s, 1'b0);
        end
        $display("[TB] midrun_reset product=%h out_valid=%0d", product_s, out_valid_s);
        start_op(1'b0, 8'h07, 8'h06, 1'b0, 16'h002A, "after_reset");
        finish_op(1'b0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seq_array_multiplier.md
Name: seq_array_multiplier

Overview:
- Parametrised, iterative shift-add multiplier for WIDTH-bit operands.
- Successor to the fixed 4-bit combinational array multiplier.
- Trades area for latency: one partial product is accumulated per clock.
- Adds a signed/unsigned mode and valid/ready handshakes on input and output, so it drops into streaming datapaths.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..32. Product is 2*WIDTH bits.
- SIGNED_EN, 1: 1 builds signed-mode support; 0 removes it, and signed_mode is ignored (unsigned only).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand pair a/b/signed_mode valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 means two's-complement operands, 0 means unsigned. Sampled with a/b.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result; two's complement when signed.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0. All internal registers (acc, mplr, mcand, count, neg) are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid (accepting edge), capture operands:
    - mcand=|a| and mplr=|b| when signed_mode and SIGNED_EN are both 1; otherwise raw a and b.
    - neg = a[MSB]^b[MSB] in signed mode, else 0.
    - acc=0, count=0; go to RUN.
- RUN, per edge:
  - sum = acc + (mplr[0] ? mcand : 0), computed WIDTH+1 bits wide to keep the carry.
  - {acc, mplr} <= {sum, mplr} >> 1 (shift right by 1).
  - count <= count+1.
  - When count==WIDTH-1, the edge also loads product = neg ? -({acc,mplr}_next) : {acc,mplr}_next, and the state moves to DONE.
- Latency:
  - out_valid rises exactly WIDTH edges after the accepting edge.
  - Throughput is one result per WIDTH+2 cycles minimum.
- DONE:
  - out_valid=1, in_ready=0. product is held stable while out_valid && !out_ready.
  - On out_ready, return to IDLE at that edge and deassert out_valid.
  - No same-cycle accept of new operands.
- Width rules:
  - Magnitudes are stored unsigned in WIDTH bits, so the most-negative value (e.g. -128 at WIDTH=8) is legal.
  - A signed product magnitude is at most 2^(2W-2), so it always fits 2*WIDTH bits signed.
  - Unsigned products use the full 2*WIDTH bits with no overflow.
- Boundaries:
  - Zero operands take the full WIDTH cycles; there is no early exit.
  - in_valid is ignored outside IDLE, and a/b may change freely then.
  - rst_n low mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and no out_valid pulse is produced.
  - out_ready high while out_valid is low has no effect.

Decomposition:
- Shared package mult_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a clog2 helper for the count width, sized for WIDTH;
  - the WIDTH range-check constants.
- No sub-module is needed. An optional abs/negate helper, twos_negate, is natural because it is used three times (|a|, |b|, final negate).

Test Plan:
- Unsigned max: WIDTH=8, signed_mode=0, a=0xFF, b=0xFF -> product=0xFE01, out_valid exactly 8 edges after accept, busy high throughout.
- Signed mixed: signed_mode=1, a=0xFD (-3), b=0x05 -> product=0xFFF1 (-15).
- Signed extreme: signed_mode=1, a=0x80, b=0x80 -> product=0x4000 (+16384).
- SIGNED_EN=0: signed_mode=1, a=0xFD, b=0x05 -> product=0x04F1 (1265, unsigned).
- Backpressure: out_ready held low 5 cycles after out_valid -> product, out_valid stable, in_ready=0. A new in_valid during that time is not accepted; in_ready returns 1 one edge after out_ready.
- Reset mid-RUN: drop rst_n at cycle 4 of 8 -> outputs go to reset values immediately, no out_valid. The next operation (0x07*0x06) yields 0x002A normally.
